adc_line_capture: RTL and testbench

- FPGA-side controller and receiver for the line-sensor ADC interface.
- On a line request it does the following, in order:
  - pulses the diode drive;
  - waits the illumination delay;
  - issues the AD_sp start pulse;
  - waits for the sensor's AD_trig;
  - captures PIXELS 16-bit samples on the generated 10 MHz ADC clock;
  - streams them out with index, valid and line-done strobes.
- Sits between the ADC pins and the line buffer / SPI readout logic.

---
 rtl/adc_line_pkg.sv | 35 +++
 rtl/line_sync_edge.sv | 32 +++
 rtl/adc_line_capture.sv | 193 +++++++++++++++++++
 tb/tb_adc_line_capture.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_line_pkg.sv
// Shared types and defaults for the line-sensor ADC capture block.
package adc_line_pkg;

   localparam int DIODE_DELAY_DEF  = 140;
   localparam int SP_WIDTH_DEF     = 10;
   localparam int PIXELS_DEF       = 518;
   localparam int DATA_W_DEF       = 16;
   localparam int CLK_DIV_DEF      = 20;
   localparam int TRIG_TIMEOUT_DEF = 1023;

   // Pixel index port width is fixed by the readout side.
   localparam int IDX_W = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DIODE_WAIT,
      ST_SP_PULSE,
      ST_TRIG_WAIT,
      ST_ARM,
      ST_CAPTURE,
      ST_DONE
   } line_state_t;

   // Bits needed to hold values 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/line_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detector for an async strobe.
// The edge pulse is high for one cycle, three cycles after the input rises.
module line_sync_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_edge
);

   logic r_meta;
   logic r_sync;
   logic r_sync_d;
   logic r_edge;

   // Resynchronize the input and register a one-cycle pulse on its rising edge.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_meta   <= 1'b0;
         r_sync   <= 1'b0;
         r_sync_d <= 1'b0;
         r_edge   <= 1'b0;
      end else begin
         r_meta   <= i_async;
         r_sync   <= r_meta;
         r_sync_d <= r_sync;
         r_edge   <= r_sync & ~r_sync_d;
      end
   end

   assign o_edge = r_edge;

endmodule

// File: rtl/adc_line_capture.sv
// Line-sensor ADC controller: diode pulse, AD_sp start, trigger wait,
// ADC clock generation and PIXELS-sample capture with streaming outputs.
module adc_line_capture
   import adc_line_pkg::*;
#(
   parameter int DIODE_DELAY  = DIODE_DELAY_DEF,
   parameter int SP_WIDTH     = SP_WIDTH_DEF,
   parameter int PIXELS       = PIXELS_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int CLK_DIV      = CLK_DIV_DEF,
   parameter int TRIG_TIMEOUT = TRIG_TIMEOUT_DEF
) (
   input  logic              clk_200MHz_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   output logic              diode_o,
   output logic              AD_sp_o,
   input  logic              AD_trig_i,
   input  logic [DATA_W-1:0] ADC_data_i,
   output logic              clk_10M_adc_o,
   output logic [DATA_W-1:0] pix_data_o,
   output logic              pix_valid_o,
   output logic [IDX_W-1:0]  pix_index_o,
   output logic              line_done_o,
   output logic              busy_o,
   output logic              err_timeout_o
);

   localparam int CNT_MAX = max3(DIODE_DELAY, SP_WIDTH, TRIG_TIMEOUT);
   localparam int CNT_W   = cnt_width(CNT_MAX);
   localparam int DIV_W   = cnt_width(CLK_DIV - 1);
   localparam int SMP_W   = cnt_width(PIXELS);

   localparam logic [CNT_W-1:0] DIODE_LAST = CNT_W'(DIODE_DELAY - 1);
   localparam logic [CNT_W-1:0] SP_LAST    = CNT_W'(SP_WIDTH - 1);
   localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_TIMEOUT - 1);
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(CLK_DIV / 2);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(PIXELS - 1);

   // ADC clock divider
   logic [DIV_W-1:0]  r_div;
   logic [DIV_W-1:0]  w_div_nxt;
   logic              r_adc_clk;

   // Input data register and synchronized trigger edge
   logic [DATA_W-1:0] r_adc_q;
   logic              w_trig_edge;

   // Sequencer state
   line_state_t       r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [SMP_W-1:0]  r_smp_cnt;

   // Registered outputs
   logic              r_diode;
   logic              r_sp;
   logic              r_err;
   logic              r_busy;
   logic              r_pix_valid;
   logic              r_line_done;
   logic [DATA_W-1:0] r_pix_data;
   logic [IDX_W-1:0]  r_pix_index;

   line_sync_edge u_trig_sync (
      .i_clk   (clk_200MHz_i),
      .i_rst_n (rst_n_i),
      .i_async (AD_trig_i),
      .o_edge  (w_trig_edge)
   );

   assign w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;

   // Free-running divider; ADC clock is high for the first half of each period.
   always_ff @(posedge clk_200MHz_i) begin
      if (!rst_n_i) begin
         r_div     <= '0;
         r_adc_clk <= 1'b0;
      end else begin
         r_div     <= w_div_nxt;
         r_adc_clk <= (w_div_nxt < DIV_HALF);
      end
   end

   // Register the ADC bus every cycle; a sample is lifted from here mid-eye.
   always_ff @(posedge clk_200MHz_i) begin
      if (!rst_n_i) begin
         r_adc_q <= '0;
      end else begin
         r_adc_q <= ADC_data_i;
      end
   end

   // Line sequencer with registered strobes; strobes default low every cycle.
   always_ff @(posedge clk_200MHz_i) begin
      if (!rst_n_i) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_smp_cnt   <= '0;
         r_diode     <= 1'b0;
         r_sp        <= 1'b0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
         r_pix_valid <= 1'b0;
         r_line_done <= 1'b0;
         r_pix_data  <= '0;
         r_pix_index <= '0;
      end else begin
         r_diode     <= 1'b0;
         r_err       <= 1'b0;
         r_pix_valid <= 1'b0;
         r_line_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  r_state <= ST_DIODE_WAIT;
                  r_diode <= 1'b1;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            ST_DIODE_WAIT: begin
               if (r_cnt == DIODE_LAST) begin
                  r_state <= ST_SP_PULSE;
                  r_sp    <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_SP_PULSE: begin
               if (r_cnt == SP_LAST) begin
                  r_state <= ST_TRIG_WAIT;
                  r_sp    <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_TRIG_WAIT: begin
               if (w_trig_edge) begin
                  r_state <= ST_ARM;
               end else if (r_cnt == TRIG_LAST) begin
                  r_state <= ST_IDLE;
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_ARM: begin
               // Start capture on the divider wrap so the ADC clock phase is known.
               if (r_div == DIV_LAST) begin
                  r_state   <= ST_CAPTURE;
                  r_smp_cnt <= '0;
               end
            end
            ST_CAPTURE: begin
               if (r_div == DIV_HALF) begin
                  // ADC clock falling edge: data has been stable for half a period.
                  r_pix_data  <= r_adc_q;
                  r_pix_index <= IDX_W'(r_smp_cnt);
                  r_pix_valid <= 1'b1;
                  r_smp_cnt   <= r_smp_cnt + 1'b1;
               end else if (r_pix_valid && (r_pix_index == IDX_LAST)) begin
                  r_state     <= ST_DONE;
                  r_line_done <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_sp    <= 1'b0;
            end
         endcase
      end
   end

   assign diode_o       = r_diode;
   assign AD_sp_o       = r_sp;
   assign clk_10M_adc_o = r_adc_clk;
   assign pix_data_o    = r_pix_data;
   assign pix_valid_o   = r_pix_valid;
   assign pix_index_o   = r_pix_index;
   assign line_done_o   = r_line_done;
   assign busy_o        = r_busy;
   assign err_timeout_o = r_err;

endmodule

// File: tb/tb_adc_line_capture.sv
// Self-checking bench for adc_line_capture: every output is compared every
// cycle against expectations derived from event times of the line protocol.
module tb_adc_line_capture;

   localparam int T_DIODE = 140;
   localparam int T_SP    = 10;
   localparam int NPIX    = 518;
   localparam int DIV     = 20;
   localparam int T_TO    = 1023;
   localparam int NONE    = -1000000;

   logic        clk_200MHz_i = 1'b0;
   logic        rst_n_i      = 1'b0;
   logic        start_i      = 1'b0;
   logic        AD_trig_i    = 1'b0;
   logic [15:0] ADC_data_i   = '0;
   logic        diode_o;
   logic        AD_sp_o;
   logic        clk_10M_adc_o;
   logic [15:0] pix_data_o;
   logic        pix_valid_o;
   logic [9:0]  pix_index_o;
   logic        line_done_o;
   logic        busy_o;
   logic        err_timeout_o;

   adc_line_capture dut (
      .clk_200MHz_i  (clk_200MHz_i),
      .rst_n_i       (rst_n_i),
      .start_i       (start_i),
      .diode_o       (diode_o),
      .AD_sp_o       (AD_sp_o),
      .AD_trig_i     (AD_trig_i),
      .ADC_data_i    (ADC_data_i),
      .clk_10M_adc_o (clk_10M_adc_o),
      .pix_data_o    (pix_data_o),
      .pix_valid_o   (pix_valid_o),
      .pix_index_o   (pix_index_o),
      .line_done_o   (line_done_o),
      .busy_o        (busy_o),
      .err_timeout_o (err_timeout_o)
   );

   always #5 clk_200MHz_i = ~clk_200MHz_i;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: absolute cycle numbers of the current line's events.
   int          step     = 0;
   int          r0       = 1 << 30;  // first cycle after reset release (divider count 1)
   int          zero_from = -1;
   bit          ln_on    = 0;
   int          s0       = NONE;
   int          t_step   = NONE;
   int          w_step   = -1;
   int          l_step   = -1;
   int          err_step = -1;
   logic [15:0] exp_data = '0;
   logic [9:0]  exp_idx  = '0;

   // Sensor model state
   bit          sns_on   = 0;
   int          sns_cnt  = 0;
   logic [15:0] sns_base = '0;
   bit          prev_clk = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h, want %h", tag, step, obs, exp);
      end
   endtask

   // First cycle at or after 'from' where the ADC divider sits at count 0.
   function automatic int next_wrap(input int from);
      int s;
      s = from;
      for (int i = 0; i < DIV; i++) begin
         if (((s - r0 + 1) % DIV) == 0) return s;
         s++;
      end
      return s;
   endfunction

   // Advance one cycle, compare all outputs with the model, run the sensor.
   task automatic tick();
      logic [6:0] e_ctl;
      logic [6:0] o_ctl;
      int         d;
      int         busy_end;
      bit         e_valid;
      @(negedge clk_200MHz_i);
      step++;
      if (step == zero_from) begin
         ln_on = 0; s0 = NONE; t_step = NONE; w_step = -1; l_step = -1; err_step = -1;
         exp_data = '0; exp_idx = '0; sns_on = 0;
      end
      e_valid = 0;
      if (w_step >= 0) begin
         d = step - (w_step + DIV / 2 + 1);
         if (d >= 0 && (d % DIV) == 0 && (d / DIV) < NPIX) begin
            e_valid  = 1;
            exp_idx  = 10'(d / DIV);
            exp_data = sns_base + 16'(d / DIV);
         end
      end
      busy_end = (err_step >= 0) ? err_step - 1 : ((l_step >= 0) ? l_step : (1 << 30));
      e_ctl = {ln_on && step == s0 + 1,
               ln_on && step >= s0 + T_DIODE + 1 && step <= s0 + T_DIODE + T_SP,
               step >= r0 && ((step - r0 + 1) % DIV) < DIV / 2,
               e_valid,
               ln_on && step == l_step,
               ln_on && step >= s0 + 1 && step <= busy_end,
               ln_on && step == err_step};
      o_ctl = {diode_o, AD_sp_o, clk_10M_adc_o, pix_valid_o, line_done_o, busy_o, err_timeout_o};
      chk("ctl{diode,sp,adcclk,valid,done,busy,err}", 32'(o_ctl), 32'(e_ctl));
      chk("pix{index,data}", {6'b0, pix_index_o, pix_data_o}, {6'b0, exp_idx, exp_data});
      // Sensor: presents a new pixel on each ADC rising edge once triggered.
      if (clk_10M_adc_o && !prev_clk) begin
         if (sns_on && step >= t_step + 5 && sns_cnt < NPIX) begin
            ADC_data_i = sns_base + 16'(sns_cnt);
            sns_cnt++;
         end else begin
            ADC_data_i = 16'($urandom);
         end
      end
      prev_clk = clk_10M_adc_o;
      start_i  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // One line request issued in the current cycle.
   //  trig_off  : cycles after AD_sp falls that AD_trig rises (<0: never)
   //  glitch    : short AD_trig pulse during SP_PULSE
   //  extras    : extra start pulses in DIODE_WAIT and CAPTURE
   //  rst_after : pulse reset right after this sample index (<0: none)
   //  done_start: also pulse start in the DONE cycle
   task automatic run_line(input int trig_off, input bit glitch, input bit extras,
                           input int rst_after, input bit done_start, input logic [15:0] base);
      bit fin;
      bit did_rst;
      fin = 0; did_rst = 0;
      s0 = step; ln_on = 1; t_step = NONE; w_step = -1; l_step = -1;
      err_step = (trig_off < 0) ? s0 + T_DIODE + T_SP + 1 + T_TO : -1;
      sns_base = base; sns_cnt = 0; sns_on = 0;
      start_i = 1'b1;
      for (int i = 0; i < 15000; i++) begin
         tick();
         if (did_rst && step == zero_from) begin
            rst_n_i = 1'b1; AD_trig_i = 1'b0; fin = 1;
            break;
         end
         if (glitch && step == s0 + T_DIODE + 2) AD_trig_i = 1'b1;
         if (glitch && step == s0 + T_DIODE + 4) AD_trig_i = 1'b0;
         if (trig_off >= 0 && step == s0 + T_DIODE + T_SP + 1 + trig_off) begin
            AD_trig_i = 1'b1;
            t_step = step;
            w_step = next_wrap(step + 5);
            l_step = w_step + DIV / 2 + 1 + DIV * (NPIX - 1) + 1;
            sns_on = 1;
         end
         if (extras && (step == s0 + 50 ||
                        (w_step >= 0 && step == w_step + DIV / 2 + 1 + DIV * 100 + 3)))
            start_i = 1'b1;
         if (rst_after >= 0 && w_step >= 0 && step == w_step + DIV / 2 + 1 + DIV * rst_after) begin
            rst_n_i = 1'b0; did_rst = 1;
            zero_from = step + 1;
            r0 = step + 2;
         end
         if (done_start && step == l_step) start_i = 1'b1;
         if (l_step >= 0 && step == l_step + 1) begin
            AD_trig_i = 1'b0; fin = 1;
            break;
         end
         if (err_step >= 0 && step == err_step) begin
            fin = 1;
            break;
         end
      end
      chk("line_reached_end", 32'(fin), 32'd1);
   endtask

   initial begin
      // Reset held for 5 clock edges, then released.
      idle(5);
      rst_n_i = 1'b1;
      r0 = step + 1;
      idle(40);
      // Full line, trigger 50 cycles after AD_sp falls.
      run_line(50, 0, 0, -1, 0, 16'h1000);
      idle(5);
      // No trigger: timeout strobe, then back to idle.
      run_line(-1, 0, 0, -1, 0, 16'h0000);
      idle(7);
      // Start pulses while busy are ignored.
      run_line(50, 0, 1, -1, 0, 16'h1000);
      idle(3);
      // Reset after sample 200, then a clean line that also pulses start in DONE.
      run_line(50, 0, 0, 200, 0, 16'h1000);
      idle(3);
      run_line(50, 0, 0, -1, 1, 16'h1000);
      // Chained straight from the cycle after DONE: glitch then valid trigger.
      run_line(60, 1, 0, -1, 0, 16'h1000);
      idle(int'($urandom_range(1, 30)));
      // Random trigger delay and data base.
      run_line(int'($urandom_range(0, 900)), 0, 0, -1, 0, 16'($urandom));
      idle(10);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit at cycle %0d", step);
      $fatal(1, "time limit");
   end

endmodule
